// File: rtl/shift_seq_pkg.sv
// Shared types and opcodes for the iterative shift sequencer.
// SHIFT_SLLV_EN adds the variable logical left shift (opcode 1011).
package shift_seq_pkg;

    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_SLLV = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [4:0] shamt_t;

    // Opcodes that are carried out step by step in the SHIFT state.
    function automatic logic is_iter_op(input logic [3:0] op);
        logic res;
        res = (op == OP_SRA) || (op == OP_SRAV);
`ifdef SHIFT_SLLV_EN
        res = res || (op == OP_SLLV);
`endif
        return res;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_step.sv
// One combinational step of the shift datapath: arithmetic right by s_i,
// or logical left for OP_SLLV when SHIFT_SLLV_EN is defined.
module shift_step_unit
    import shift_seq_pkg::*;
(
    input  logic [31:0] val_i,
    input  shamt_t      s_i,
    input  logic [3:0]  op_i,
    output logic [31:0] val_o
);

`ifndef SHIFT_SLLV_EN
    logic unused_op;
    assign unused_op = ^op_i;
`endif

    always_comb begin
        val_o = $signed(val_i) >>> s_i;
`ifdef SHIFT_SLLV_EN
        if (op_i == OP_SLLV) begin
            val_o = val_i << s_i;
        end
`endif
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer beside the EX-stage ALU; shifts up to SHIFT_STEP
// bits per cycle. Optional SHIFT_SLLV_EN enables opcode 1011 (variable SLL).
//
// state    | meaning
// ST_IDLE  | ready for a request; data_o holds last result
// ST_SHIFT | iterating val_q by min(rem_q, SHIFT_STEP) per cycle
// ST_DONE  | done_o pulse; data_o valid
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [3:0]  ALUCtrl_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] data_o
);

    localparam shamt_t STEP = shamt_t'(SHIFT_STEP);

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    shamt_t      rem_q, rem_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] data_q, data_d;

    shamt_t      step_s;
    logic [31:0] step_val;

    logic unused_src2;
    assign unused_src2 = ^src2_i[31:5];

    assign step_s = (rem_q < STEP) ? rem_q : STEP;

    shift_step_unit u_step (
        .val_i (val_q),
        .s_i   (step_s),
        .op_i  (op_q),
        .val_o (step_val)
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rem_d   = rem_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_iter_op(ALUCtrl_i)) begin
                        val_d   = src1_i;
                        rem_d   = src2_i[4:0];
                        op_d    = ALUCtrl_i;
                        state_d = ST_SHIFT;
                    end else if (ALUCtrl_i == OP_LUI) begin
                        data_d  = src1_i << 16;
                        state_d = ST_DONE;
                    end else begin
                        data_d  = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (rem_q != '0) begin
                    val_d = step_val;
                    rem_d = rem_q - step_s;
                end else begin
                    data_d  = val_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done_o  = (state_q == ST_DONE);
    assign data_o  = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: four sequencers (SHIFT_STEP 1, 4, 16, 8) share one stimulus
// stream; latency is counted in edges after the accept edge.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [3:0]  alu = '0;

    logic        ready [4];
    logic        busy  [4];
    logic        done  [4];
    logic [31:0] data  [4];

    int n_total = 0;
    int n_pass  = 0;
    int lat [4];
    logic [31:0] dat [4];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.SHIFT_STEP(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
        .ALUCtrl_i(alu), .ready_o(ready[0]), .busy_o(busy[0]), .done_o(done[0]), .data_o(data[0]));
    shift_seq_ctrl #(.SHIFT_STEP(4)) u_s4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
        .ALUCtrl_i(alu), .ready_o(ready[1]), .busy_o(busy[1]), .done_o(done[1]), .data_o(data[1]));
    shift_seq_ctrl #(.SHIFT_STEP(16)) u_s16 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
        .ALUCtrl_i(alu), .ready_o(ready[2]), .busy_o(busy[2]), .done_o(done[2]), .data_o(data[2]));
    shift_seq_ctrl #(.SHIFT_STEP(8)) u_s8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
        .ALUCtrl_i(alu), .ready_o(ready[3]), .busy_o(busy[3]), .done_o(done[3]), .data_o(data[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Pulse start for one cycle, then record first done cycle and data per DUT.
    // lat = number of edges after the accept edge; -1 if done never pulsed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        alu   = op;
        src1  = a;
        src2  = b;
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1;
            dat[i] = 'x;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (done[i] && lat[i] < 0) begin
                    lat[i] = c;
                    dat[i] = data[i];
                end
            end
        end
    endtask

    task automatic check_run(input string tag, input int l0, input int l1, input int l2,
                             input int l3, input logic [31:0] exp_data);
        int el [4];
        el[0] = l0; el[1] = l1; el[2] = l2; el[3] = l3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(el[i]));
            check($sformatf("%s_data%0d", tag, i), dat[i], exp_data);
            check($sformatf("%s_hold%0d", tag, i), data[i], exp_data);
        end
    endtask

    initial begin
        logic       saw_done;
        logic       ready_err;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("rst_busy%0d", i),  32'(busy[i]),  32'd0);
            check($sformatf("rst_done%0d", i),  32'(done[i]),  32'd0);
            check($sformatf("rst_data%0d", i),  data[i],       32'h0);
        end
        rst = 1'b0;

        // steps (1,4,16,8)
        run_op(4'b1000, 32'h8000_0000, 32'd5);
        check_run("sra5", 6, 3, 2, 2, 32'hFC00_0000);
        run_op(4'b1001, 32'h7FFF_FFF0, 32'h23);
        check_run("srav3", 4, 2, 2, 2, 32'h0FFF_FFFE);
        run_op(4'b1001, 32'h7FFF_FFF0, 32'h0);
        check_run("srav0", 1, 1, 1, 1, 32'h7FFF_FFF0);
        run_op(4'b1010, 32'h0000_1234, 32'h0);
        check_run("lui", 0, 0, 0, 0, 32'h1234_0000);
        run_op(4'b0110, 32'h0000_1234, 32'h7);
        check_run("illegal", 0, 0, 0, 0, 32'h0);
        run_op(4'b1000, 32'hFFFF_0000, 32'd31);
        check_run("max31", 32, 9, 3, 5, 32'hFFFF_FFFF);
        run_op(4'b1011, 32'h0000_0001, 32'd31);
`ifdef SHIFT_SLLV_EN
        check_run("sllv", 32, 9, 3, 5, 32'h8000_0000);
`else
        check_run("sllv_off", 0, 0, 0, 0, 32'h0);
`endif

        // start held high through SHIFT/DONE with different operands (step=1 unit)
        @(negedge clk);
        start = 1'b1; alu = 4'b1000; src1 = 32'h8000_0000; src2 = 32'd5;
        saw_done = 1'b0;
        ready_err = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            alu = 4'b1010; src1 = 32'hDEAD_BEEF; src2 = 32'd1;
            if (c <= 6 && ready[0]) ready_err = 1'b1;
            if (c < 6 && done[0]) saw_done = 1'b1;
            if (c == 6) begin
                check("busy_done", 32'(done[0]), 32'd1);
                check("busy_data", data[0], 32'hFC00_0000);
            end
            if (c == 7) check("busy_ready_after", 32'(ready[0]), 32'd1);
            if (c == 8) begin
                check("b2b_done", 32'(done[0]), 32'd1);
                check("b2b_data", data[0], 32'hBEEF_0000);
            end
        end
        check("busy_ready_low", 32'(ready_err), 32'd0);
        check("busy_no_early_done", 32'(saw_done), 32'd0);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // reset during SHIFT aborts with no done pulse
        start = 1'b1; alu = 4'b1000; src1 = 32'h8000_0000; src2 = 32'd5;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 2) begin
                check("pre_rst_busy", 32'(busy[0]), 32'd1);
                rst = 1'b1;
            end
            if (c == 3) begin
                rst = 1'b0;
                check("mid_rst_ready", 32'(ready[0]), 32'd1);
                check("mid_rst_busy", 32'(busy[0]), 32'd0);
                check("mid_rst_data", data[0], 32'h0);
            end
            if (done[0]) saw_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(saw_done), 32'd0);
        check("mid_rst_data_end", data[0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer for the CPU shift unit.
- Accepts one shift request, performs it iteratively with a small fixed-width step shifter, and returns the result with a done pulse.
- Sits beside the ALU in the EX stage; ready_o/busy_o drive the pipeline stall logic while a variable shift is in flight.
- Opcode encoding matches the ALU control field: 1000/1001 arithmetic right by src2, 1010 shift left by 16 (LUI), anything else yields 0.

Parameters:
SHIFT_STEP, 1, maximum bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-high
start_i  input  1  request strobe; accepted only when ready_o=1
src1_i  input  32  value to shift
src2_i  input  32  shift amount; only bits [4:0] are used
ALUCtrl_i  input  4  operation code
ready_o  output  1  1 only in IDLE
busy_o  output  1  1 in SHIFT and DONE
done_o  output  1  one-cycle pulse, result valid
data_o  output  32  result; held from done until the next accepted start

Behaviour:
- Reset, synchronous, active-high: state=IDLE, ready_o=1, busy_o=0, done_o=0, data_o=0, internal value/remaining/op registers=0.
- Reset asserted mid-operation aborts the operation with no done pulse; it has priority over all other inputs.
- States: IDLE, SHIFT, DONE.
- IDLE with start_i=1 at edge E0 (accept):
  - ALUCtrl_i 1000/1001: val=src1_i, rem=src2_i[4:0], go to SHIFT.
  - ALUCtrl_i 1010: data_o=src1_i<<16, go to DONE.
  - Any other code: data_o=0, go to DONE.
- IDLE with start_i=0: stay in IDLE; data_o holds.
- SHIFT, rem>0: s=min(rem, SHIFT_STEP); val=$signed(val)>>>s; rem=rem-s; stay in SHIFT.
  - s is always a power-of-two-bounded value ≤ 31, so no overflow on rem.
- SHIFT, rem=0: data_o=val, go to DONE.
- DONE: done_o=1 for exactly this cycle; next edge goes to IDLE.
- Latency: with k=ceil(amt/SHIFT_STEP), done_o is high in the cycle after edge E0+k+1.
  - amt=0 gives done after E0+1.
  - LUI and default codes give done after E0.
- start_i while busy is ignored and not queued. start_i during the DONE cycle is also ignored; the requester must re-assert while ready_o=1.
- Inputs are sampled only at the accept edge; changes to src*/ALUCtrl_i during SHIFT have no effect.
- Arithmetic right shift replicates src1[31]; shift amounts ≥ 32 cannot occur because only 5 bits are used.

Optional Feature:
SHIFT_SLLV_EN
- Defined: ALUCtrl_i 1011 is a variable logical left shift by src2_i[4:0]. It uses the SHIFT state with val=val<<s and has the same latency rule as the right shifts.
- Undefined: 1011 falls into the default case, producing data_o=0 and done after E0.

Decomposition:
- Package shift_seq_pkg:
  - opcode localparams OP_SRA=4'b1000, OP_SRAV=4'b1001, OP_LUI=4'b1010, OP_SLLV=4'b1011
  - state encoding typedef (IDLE/SHIFT/DONE)
  - 5-bit shift-amount typedef
- One combinational sub-module, shift_step_unit: inputs val, s, op; output val shifted by s (arithmetic right, or logical left under SHIFT_SLLV_EN). The FSM and counters stay in shift_seq_ctrl.

Test Plan:
- Reset mid-shift: SHIFT_STEP=1, src1=0x80000000, src2=5, op=1000 -> done_o high after E0+6 with data_o=0xFC000000; rst_i=1 at E0+3 -> IDLE, done_o never pulses, data_o=0.
- Step and zero amount: SHIFT_STEP=4, src1=0x7FFFFFF0, src2=0x23 (amt=3), op=1001 -> done after E0+2, data_o=0x0FFFFFFE; src2=0 -> done after E0+1, data_o=src1.
- LUI and illegal code: op=1010, src1=0x00001234 -> done after E0, data_o=0x12340000; op=0110 -> done after E0, data_o=0.
- Busy-time start: assert start_i with new values during SHIFT and DONE -> ignored; first result unchanged, ready_o=0 throughout; back-to-back accept succeeds on the first IDLE cycle.
- Maximum amount: SHIFT_STEP=1, src1=0xFFFF0000, src2=31 -> done after E0+32, data_o=0xFFFFFFFF; SHIFT_STEP=16, same inputs -> done after E0+3.
- Feature on (SHIFT_SLLV_EN defined): op=1011, src1=1, src2=31, SHIFT_STEP=8 -> done after E0+5, data_o=0x80000000. Feature off -> data_o=0 after E0.
